// File: rtl/data_mem_responder.sv
// data_mem_responder: responder side of the inner memory interface.
// Word-organised synchronous RAM with byte-lane writes, load sizing/extension and
// misalignment detection. The RAM is zero-filled after reset before requests are honoured.
module data_mem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr_out,
   input  logic        MemRW,
   input  logic [2:0]  RWType,
   input  logic [31:0] data_out,
   output logic [31:0] data_in,
   output logic        misalign,
   output logic        mem_ready
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam logic [AW-1:0] LastIdx = AW'(DEPTH_WORDS - 1);

   typedef enum logic [0:0] {StClear, StReady} state_e;

   state_e          state_q;
   logic [AW-1:0]   sweep_q;
   logic            mem_ready_q;
   logic            misalign_q;
   logic            ld_en_q;
   logic [1:0]      off_q;
   logic [2:0]      type_q;
   logic [31:0]     rd_word_q;

   logic [31:0]     mem_q [DEPTH_WORDS];

   logic [AW-1:0]   word_idx;
   logic [1:0]      offset;
   logic            ld_sup, st_sup, is_half, is_word;
   logic            mis_addr, req_sup, store_en;
   logic [3:0]      wr_be;
   logic [31:0]     wr_data;

   // Upper address bits are deliberately ignored so addresses wrap.
   logic            unused_addr;
   assign unused_addr = ^addr_out[31:AW+2];

   assign word_idx = addr_out[AW+1:2];
   assign offset   = addr_out[1:0];

   // Decode the access size and which request kinds support it.
   always_comb begin
      ld_sup  = 1'b0;
      st_sup  = 1'b0;
      is_half = 1'b0;
      is_word = 1'b0;
      case (RWType)
         3'b000: begin ld_sup = 1'b1; st_sup = 1'b1; end
         3'b001: begin ld_sup = 1'b1; st_sup = 1'b1; is_half = 1'b1; end
         3'b010: begin ld_sup = 1'b1; st_sup = 1'b1; is_word = 1'b1; end
         3'b100: begin ld_sup = 1'b1; end
         3'b101: begin ld_sup = 1'b1; is_half = 1'b1; end
         default: begin ld_sup = 1'b0; end
      endcase
      mis_addr = (is_half && offset[0]) || (is_word && (offset != 2'b00));
      req_sup  = MemRW ? st_sup : ld_sup;
      store_en = (state_q == StReady) && MemRW && st_sup && !mis_addr;
   end

   // Byte-lane enables and lane-replicated write data for stores.
   always_comb begin
      wr_be   = 4'b0000;
      wr_data = data_out;
      if (is_word) begin
         wr_be = 4'b1111;
      end else if (is_half) begin
         wr_be   = offset[1] ? 4'b1100 : 4'b0011;
         wr_data = {2{data_out[15:0]}};
      end else begin
         wr_be   = 4'b0001 << offset;
         wr_data = {4{data_out[7:0]}};
      end
   end

   // RAM: sweep zeroes during CLEAR, byte-lane stores and synchronous reads in READY.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state_q == StClear) begin
            mem_q[sweep_q] <= '0;
         end else begin
            if (store_en) begin
               for (int i = 0; i < 4; i++) begin
                  if (wr_be[i]) mem_q[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
               end
            end
            rd_word_q <= mem_q[word_idx];
         end
      end
   end

   // Control FSM with registered status and load-side pipeline state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StClear;
         sweep_q     <= '0;
         mem_ready_q <= 1'b0;
         misalign_q  <= 1'b0;
         ld_en_q     <= 1'b0;
         off_q       <= 2'b00;
         type_q      <= 3'b000;
      end else begin
         case (state_q)
            StClear: begin
               misalign_q <= 1'b0;
               ld_en_q    <= 1'b0;
               sweep_q    <= sweep_q + 1'b1;
               if (sweep_q == LastIdx) begin
                  state_q     <= StReady;
                  mem_ready_q <= 1'b1;
               end
            end
            StReady: begin
               misalign_q <= req_sup && mis_addr;
               ld_en_q    <= !MemRW && ld_sup && !mis_addr;
               off_q      <= offset;
               type_q     <= RWType;
            end
            default: state_q <= StClear;
         endcase
      end
   end

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   // Extract and extend the load result from the word read last cycle.
   always_comb begin
      data_in = '0;
      ld_byte = rd_word_q[{off_q, 3'b000} +: 8];
      ld_half = off_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];
      if (ld_en_q) begin
         case (type_q)
            3'b000:  data_in = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  data_in = {24'b0, ld_byte};
            3'b001:  data_in = {{16{ld_half[15]}}, ld_half};
            3'b101:  data_in = {16'b0, ld_half};
            3'b010:  data_in = rd_word_q;
            default: data_in = '0;
         endcase
      end
   end

   assign misalign  = misalign_q;
   assign mem_ready = mem_ready_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed vectors with literal expectations plus a
// behavioural memory model compared against the DUT outputs every cycle.
module tb_data_mem_responder;

   localparam int unsigned DEPTH = 16;

   logic        clk;
   logic        rst;
   logic [31:0] addr;
   logic        mrw;
   logic [2:0]  rwt;
   logic [31:0] dout;
   logic [31:0] din;
   logic        mis;
   logic        rdy;

   int checks = 0;
   int errors = 0;

   data_mem_responder #(.DEPTH_WORDS(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .addr_out (addr),
      .MemRW    (mrw),
      .RWType   (rwt),
      .data_out (dout),
      .data_in  (din),
      .misalign (mis),
      .mem_ready(rdy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] m [DEPTH];
   int          cnt;
   logic        exp_ready;
   logic        exp_mis;
   logic [31:0] exp_data;

   task automatic model_req();
      int w, off, n;
      logic sup, sgn;
      logic [31:0] v;
      w   = int'(addr[5:2]);
      off = int'(addr[1:0]);
      case (rwt)
         3'd0: n = 1;
         3'd1: n = 2;
         3'd2: n = 4;
         3'd4: n = 1;
         3'd5: n = 2;
         default: n = 0;
      endcase
      sup = (n != 0) && !(mrw && rwt[2]);
      sgn = !rwt[2];
      exp_mis  = sup ? ((off % n) != 0) : 1'b0;
      exp_data = '0;
      if (sup && !exp_mis) begin
         if (mrw) begin
            for (int i = 0; i < n; i++) m[w][8*(off+i) +: 8] = dout[8*i +: 8];
         end else begin
            v = m[w] >> (8 * off);
            if (n == 1) begin
               v = v & 32'hFF;
               if (sgn && v[7]) v = v | 32'hFFFF_FF00;
            end else if (n == 2) begin
               v = v & 32'hFFFF;
               if (sgn && v[15]) v = v | 32'hFFFF_0000;
            end
            exp_data = v;
         end
      end
   endtask

   initial begin
      exp_ready = 1'b0;
      exp_mis   = 1'b0;
      exp_data  = '0;
      cnt       = 0;
      for (int i = 0; i < DEPTH; i++) m[i] = 32'h5A5A_5A5A;
      forever begin
         @(posedge clk);
         if (rst) begin
            cnt = 0; exp_ready = 1'b0; exp_data = '0; exp_mis = 1'b0;
         end else if (!exp_ready) begin
            m[cnt] = '0;
            cnt++;
            exp_ready = (cnt == DEPTH);
            exp_data  = '0;
            exp_mis   = 1'b0;
         end else begin
            model_req();
         end
      end
   end

   // Every-cycle comparison against the model.
   initial begin
      forever begin
         @(negedge clk);
         chk("model_mem_ready", {31'b0, rdy}, {31'b0, exp_ready});
         chk("model_misalign", {31'b0, mis}, {31'b0, exp_mis});
         chk("model_data_in", din, exp_data);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic idle();
      addr = 32'h0; mrw = 1'b0; rwt = 3'b010; dout = 32'h0;
   endtask

   task automatic issue(input logic [31:0] a, input logic w, input logic [2:0] t,
                        input logic [31:0] d);
      addr = a; mrw = w; rwt = t; dout = d;
      @(posedge clk);
      #1;
   endtask

   task automatic lit(input string name, input logic [31:0] ed, input logic em);
      chk({name, "_data"}, din, ed);
      chk({name, "_mis"}, {31'b0, mis}, {31'b0, em});
   endtask

   task automatic ld(input string name, input logic [31:0] a, input logic [2:0] t,
                     input logic [31:0] ed, input logic em);
      issue(a, 1'b0, t, 32'h0);
      lit(name, ed, em);
   endtask

   task automatic st(input string name, input logic [31:0] a, input logic [2:0] t,
                     input logic [31:0] d, input logic em);
      issue(a, 1'b1, t, d);
      lit(name, 32'h0, em);
   endtask

   task automatic clear_window(input string name);
      for (int i = 1; i <= DEPTH; i++) begin
         @(posedge clk);
         #1;
         chk(name, {31'b0, rdy}, (i == DEPTH) ? 32'd1 : 32'd0);
      end
   endtask

   initial begin
      rst = 1'b1;
      idle();
      repeat (3) @(posedge clk);
      #1;
      chk("reset_ready", {31'b0, rdy}, 32'd0);
      lit("reset", 32'h0, 1'b0);
      rst = 1'b0;
      clear_window("clear_ready");

      ld("lw_0", 32'h0000_0000, 3'b010, 32'h0, 1'b0);
      ld("lw_3c", 32'h0000_003C, 3'b010, 32'h0, 1'b0);

      st("sw_10", 32'h0000_0010, 3'b010, 32'h8000_00F0, 1'b0);
      ld("lb_10", 32'h0000_0010, 3'b000, 32'hFFFF_FFF0, 1'b0);
      ld("lbu_10", 32'h0000_0010, 3'b100, 32'h0000_00F0, 1'b0);
      ld("lh_12", 32'h0000_0012, 3'b001, 32'hFFFF_8000, 1'b0);
      ld("lhu_12", 32'h0000_0012, 3'b101, 32'h0000_8000, 1'b0);
      ld("lw_10", 32'h0000_0010, 3'b010, 32'h8000_00F0, 1'b0);

      st("sw_20", 32'h0000_0020, 3'b010, 32'h1122_3344, 1'b0);
      st("sb_21", 32'h0000_0021, 3'b000, 32'h1234_56AA, 1'b0);
      st("sh_22", 32'h0000_0022, 3'b001, 32'hDEAD_BEEF, 1'b0);
      ld("lw_20_merge", 32'h0000_0020, 3'b010, 32'hBEEF_AA44, 1'b0);

      st("sh_21_mis", 32'h0000_0021, 3'b001, 32'h0000_5555, 1'b1);
      ld("lw_20_after_sh", 32'h0000_0020, 3'b010, 32'hBEEF_AA44, 1'b0);
      st("sw_22_mis", 32'h0000_0022, 3'b010, 32'h1234_5678, 1'b1);
      ld("lw_20_after_sw", 32'h0000_0020, 3'b010, 32'hBEEF_AA44, 1'b0);
      ld("lw_23_mis", 32'h0000_0023, 3'b010, 32'h0, 1'b1);
      ld("lhu_21_mis", 32'h0000_0021, 3'b101, 32'h0, 1'b1);

      st("st_bu_type", 32'h0000_0020, 3'b100, 32'h0000_0000, 1'b0);
      st("st_hu_type", 32'h0000_0021, 3'b101, 32'h0000_0000, 1'b0);
      ld("lw_20_after_bad", 32'h0000_0020, 3'b010, 32'hBEEF_AA44, 1'b0);
      ld("ld_bad_type", 32'h0000_0020, 3'b011, 32'h0, 1'b0);
      ld("lb_23", 32'h0000_0023, 3'b000, 32'hFFFF_FFBE, 1'b0);

      st("sw_40_wrap", 32'h0000_0040, 3'b010, 32'hCAFE_F00D, 1'b0);
      ld("lw_0_wrap", 32'h0000_0000, 3'b010, 32'hCAFE_F00D, 1'b0);
      ld("lw_hi_wrap", 32'hFFFF_FFC0, 3'b010, 32'hCAFE_F00D, 1'b0);

      // Reset while READY, then again mid-sweep at index 7.
      idle();
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_ready_drop", {31'b0, rdy}, 32'd0);
      rst = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear_window("reclear_ready");
      ld("lw_0_cleared", 32'h0000_0000, 3'b010, 32'h0, 1'b0);
      ld("lw_20_cleared", 32'h0000_0020, 3'b010, 32'h0, 1'b0);

      idle();
      @(posedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
